// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined adder: operation mode encoding and slice sizing.
package alu_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Width of one carry-chain slice. The top level rejects a WIDTH that does not divide evenly.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One SW-bit slice of the carry chain: sum, carry out, and the carry into the slice MSB.
module adder_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          cin_i,
    output logic [SW-1:0] sum_o,
    output logic          cout_o,
    output logic          cmsb_o
);

    logic [SW:0] total_s;

    assign total_s = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, cin_i};
    assign sum_o   = total_s[SW-1:0];
    assign cout_o  = total_s[SW];
    // The MSB sum bit is a ^ b ^ carry-in, so the carry into it can be recovered without a second adder.
    assign cmsb_o  = a_i[SW-1] ^ b_i[SW-1] ^ total_s[SW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one carry-chain slice per stage, with the high operand slices skewed forward.
module pipelined_adder
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int SW   = slice_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if ((WIDTH % STAGES) != 0) begin : g_width_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic             adv_s;
    logic             out_valid_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;
    logic             overflow_q;
    logic             zero_q;

    // The whole pipeline advances together whenever the output register is free or being drained.
    assign adv_s      = ~out_valid_s | out_ready_i;
    assign in_ready_o = adv_s;

    // Effective B operand and carry-in for the selected mode.
    always_comb begin
        b_eff_s   = b_i;
        cin_eff_s = cin_i;
        if (sub_i == SUB) begin
            b_eff_s   = ~b_i;
            cin_eff_s = 1'b1;
        end else begin
            b_eff_s   = b_i;
            cin_eff_s = cin_i;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - k * SW;

        logic [RW-1:0]       a_in_s;
        logic [RW-1:0]       b_in_s;
        logic                c_in_s;
        logic                v_in_s;
        logic                load_s;
        logic [SW-1:0]       slice_sum_s;
        logic                slice_cout_s;
        logic                slice_cmsb_s;
        logic [(k+1)*SW-1:0] sum_d;
        logic [(k+1)*SW-1:0] sum_q;
        logic                c_q;
        logic                v_q;

        if (k == 0) begin : g_src
            assign a_in_s = a_i;
            assign b_in_s = b_eff_s;
            assign c_in_s = cin_eff_s;
            assign v_in_s = in_valid_i;
            assign sum_d  = slice_sum_s;
        end else begin : g_src
            assign a_in_s = g_st[k-1].g_skew.a_q;
            assign b_in_s = g_st[k-1].g_skew.b_q;
            assign c_in_s = g_st[k-1].c_q;
            assign v_in_s = g_st[k-1].v_q;
            assign sum_d  = {slice_sum_s, g_st[k-1].sum_q};
        end

        adder_slice #(
            .SW(SW)
        ) u_slice (
            .a_i   (a_in_s[SW-1:0]),
            .b_i   (b_in_s[SW-1:0]),
            .cin_i (c_in_s),
            .sum_o (slice_sum_s),
            .cout_o(slice_cout_s),
            .cmsb_o(slice_cmsb_s)
        );

        // Data only moves with a real beat, so idle stages (and the outputs) keep their last values.
        assign load_s = adv_s & v_in_s;

        // Stage valid bit: flush wins even while stalled.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                v_q <= 1'b0;
            end else if (flush_i) begin
                v_q <= 1'b0;
            end else if (adv_s) begin
                v_q <= v_in_s;
            end else begin
                v_q <= v_q;
            end
        end

        // Completed low slices and the carry handed to the next stage.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (load_s) begin
                sum_q <= sum_d;
                c_q   <= slice_cout_s;
            end else begin
                sum_q <= sum_q;
                c_q   <= c_q;
            end
        end

        if (k < LAST) begin : g_skew
            logic [RW-SW-1:0] a_q;
            logic [RW-SW-1:0] b_q;

            // Unprocessed high operand slices travel with the beat.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load_s) begin
                    a_q <= a_in_s[RW-1:SW];
                    b_q <= b_in_s[RW-1:SW];
                end else begin
                    a_q <= a_q;
                    b_q <= b_q;
                end
            end
        end
    end

    // Flags derived from the final slice, registered alongside the result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (g_st[LAST].load_s) begin
            overflow_q <= g_st[LAST].slice_cmsb_s ^ g_st[LAST].slice_cout_s;
            zero_q     <= (g_st[LAST].sum_d == {WIDTH{1'b0}});
        end else begin
            overflow_q <= overflow_q;
            zero_q     <= zero_q;
        end
    end

    assign out_valid_s = g_st[LAST].v_q;
    assign out_valid_o = out_valid_s;
    assign sum_o       = g_st[LAST].sum_q;
    assign cout_o      = g_st[LAST].c_q;
    assign overflow_o  = overflow_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on a 4-stage instance plus a random sweep over 1/2/8/32 stages.
module tb_pipelined_adder;

    localparam int NSW   = 4;
    localparam int NBEAT = 1000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    logic        sw_in_valid  [NSW];
    logic        sw_in_ready  [NSW];
    logic [31:0] sw_a         [NSW];
    logic [31:0] sw_b         [NSW];
    logic        sw_cin       [NSW];
    logic        sw_sub       [NSW];
    logic        sw_out_valid [NSW];
    logic        sw_out_ready [NSW];
    logic [31:0] sw_sum       [NSW];
    logic        sw_cout      [NSW];
    logic        sw_ovf       [NSW];
    logic        sw_zero      [NSW];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .sum_o(sum),
        .cout_o(cout), .overflow_o(ovf), .zero_o(zero)
    );

    for (genvar g = 0; g < NSW; g++) begin : g_sweep
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 32;
        pipelined_adder #(.WIDTH(32), .STAGES(ST)) u_sw (
            .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(sw_in_valid[g]), .in_ready_o(sw_in_ready[g]),
            .a_i(sw_a[g]), .b_i(sw_b[g]), .cin_i(sw_cin[g]), .sub_i(sw_sub[g]), .flush_i(flush),
            .out_valid_o(sw_out_valid[g]), .out_ready_i(sw_out_ready[g]), .sum_o(sw_sum[g]),
            .cout_o(sw_cout[g]), .overflow_o(sw_ovf[g]), .zero_o(sw_zero[g])
        );
    end

    // Reference: exact integer arithmetic; returns {cout, overflow, zero, sum}.
    function automatic logic [34:0] ref_model(input logic [31:0] av, input logic [31:0] bv,
                                              input logic cv, input logic sv);
        longint ua, ub, sa, sb, ures, sres;
        logic [31:0] s;
        logic co, ov;
        ua = longint'({32'd0, av});
        ub = longint'({32'd0, bv});
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (sv) begin
            ures = ua - ub;
            sres = sa - sb;
            co   = (ua >= ub);
        end else begin
            ures = ua + ub + longint'({63'd0, cv});
            sres = sa + sb + longint'({63'd0, cv});
            co   = (ures >= 64'sd4294967296);
        end
        s  = ures[31:0];
        ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return {co, ov, (s == 32'd0), s};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic run_one(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                           input logic sv, output logic [34:0] got, output int lat);
        @(negedge clk);
        in_valid = 1'b1; a = av; b = bv; cin = cv; sub = sv; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        got = {cout, ovf, zero, sum};
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if ({sum, cout, ovf, zero} !== 35'd0) begin failures++; $display("FAIL rst_data got=%h/%b%b%b exp=0", sum, cout, ovf, zero); end
        for (int i = 0; i < NSW; i++) begin
            checks++; if (sw_out_valid[i] !== 1'b0 || sw_sum[i] !== 32'd0) begin failures++; $display("FAIL rst_sweep inst=%0d valid=%b sum=%h exp=0", i, sw_out_valid[i], sw_sum[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_wrap();
        logic [34:0] got; int lat;
        run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, got, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL add_latency got=%0d exp=4", lat); end
        checks++; if (got !== {1'b1, 1'b0, 1'b1, 32'h0000_0000}) begin failures++; $display("FAIL add_wrap got=%h exp=%h", got, {1'b1, 1'b0, 1'b1, 32'h0}); end
    endtask

    task automatic test_overflow();
        logic [34:0] got; int lat;
        run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, got, lat);
        checks++; if (got !== {1'b0, 1'b1, 1'b0, 32'h8000_0000}) begin failures++; $display("FAIL ovf_add got=%h exp=%h lat=%0d", got, {1'b0, 1'b1, 1'b0, 32'h8000_0000}, lat); end
        run_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, got, lat);
        checks++; if (got !== {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF}) begin failures++; $display("FAIL ovf_sub got=%h exp=%h lat=%0d", got, {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF}, lat); end
    endtask

    task automatic test_sub();
        logic [34:0] got; int lat;
        run_one(32'd5, 32'd7, 1'b1, 1'b1, got, lat);
        checks++; if (got !== {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE}) begin failures++; $display("FAIL sub_5_7 got=%h exp=%h lat=%0d", got, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE}, lat); end
        run_one(32'd7, 32'd5, 1'b0, 1'b1, got, lat);
        checks++; if (got !== {1'b1, 1'b0, 1'b0, 32'h0000_0002}) begin failures++; $display("FAIL sub_7_5 got=%h exp=%h lat=%0d", got, {1'b1, 1'b0, 1'b0, 32'h2}, lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got_q[$];
        int sent = 0;
        int c = 0;
        while ((sent < 8 || got_q.size() < 8) && c < 200) begin
            @(negedge clk);
            out_ready = !(c >= 6 && c <= 9);
            in_valid  = (sent < 8);
            a = 32'(sent); b = 32'(sent); cin = 1'b0; sub = 1'b0;
            #1;
            if (c >= 6 && c <= 9) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, in_ready); end
            end
            if (out_valid && out_ready) got_q.push_back(sum);
            if (in_valid && in_ready) sent++;
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got_q.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== 32'(2 * i)) begin failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got_q[i], 32'(2 * i)); end
        end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        int lat;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'(100 + j); b = 32'(j); sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        end
        @(negedge clk);
        a = 32'd55; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_next got=%b exp=0", out_valid); end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stale cycle=%0d got=%b sum=%h exp=0", j, out_valid, sum); end
        end
        // Flush coinciding with consumption of a valid output beat.
        @(negedge clk);
        in_valid = 1'b1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        checks++; if (out_valid !== 1'b1 || sum !== 32'd18) begin failures++; $display("FAIL flush_pre got=%b/%h exp=1/12", out_valid, sum); end
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_consume got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'(j + 3); b = 32'd1; sub = 1'b0; cin = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        checks++; if ({sum, cout, ovf, zero} !== 35'd0) begin failures++; $display("FAIL rstmid_data got=%h/%b%b%b exp=0", sum, cout, ovf, zero); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale cycle=%0d got=%b exp=0", j, out_valid); end
        end
    endtask

    task automatic test_sweep();
        logic [34:0] exp_q [NSW][$];
        int sent [NSW];
        int recv [NSW];
        int cyc = 0;
        bit busy = 1'b1;
        logic [34:0] e;
        for (int i = 0; i < NSW; i++) begin sent[i] = 0; recv[i] = 0; end
        while (busy && cyc < 20000) begin
            @(negedge clk);
            for (int i = 0; i < NSW; i++) begin
                sw_out_ready[i] = ($urandom_range(0, 3) != 0);
                if (sent[i] < NBEAT && $urandom_range(0, 3) != 0) begin
                    sw_in_valid[i] = 1'b1;
                    sw_a[i]   = pick_operand();
                    sw_b[i]   = pick_operand();
                    sw_cin[i] = 1'($urandom_range(0, 1));
                    sw_sub[i] = 1'($urandom_range(0, 1));
                end else begin
                    sw_in_valid[i] = 1'b0;
                end
            end
            #1;
            busy = 1'b0;
            for (int i = 0; i < NSW; i++) begin
                if (sw_out_valid[i] && sw_out_ready[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        failures++; $display("FAIL sweep_extra inst=%0d got=%h exp=none", i, sw_sum[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        if ({sw_cout[i], sw_ovf[i], sw_zero[i], sw_sum[i]} !== e) begin
                            failures++;
                            $display("FAIL sweep_result inst=%0d beat=%0d got=%h exp=%h", i, recv[i],
                                     {sw_cout[i], sw_ovf[i], sw_zero[i], sw_sum[i]}, e);
                        end
                    end
                    recv[i]++;
                end
                if (sw_in_valid[i] && sw_in_ready[i]) begin
                    exp_q[i].push_back(ref_model(sw_a[i], sw_b[i], sw_cin[i], sw_sub[i]));
                    sent[i]++;
                end
                if (sent[i] < NBEAT || recv[i] < NBEAT) busy = 1'b1;
            end
            cyc++;
        end
        for (int i = 0; i < NSW; i++) begin
            sw_in_valid[i] = 1'b0;
            checks++; if (recv[i] != NBEAT) begin failures++; $display("FAIL sweep_count inst=%0d got=%0d exp=%0d", i, recv[i], NBEAT); end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = 32'd0; b = 32'd0; cin = 1'b0; sub = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < NSW; i++) begin
            sw_in_valid[i] = 1'b0; sw_a[i] = 32'd0; sw_b[i] = 32'd0; sw_cin[i] = 1'b0;
            sw_sub[i] = 1'b0; sw_out_ready[i] = 1'b1;
        end
        test_reset();
        test_add_wrap();
        test_overflow();
        test_sub();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
